// File: rtl/data_mem_ctrl.sv
// Data memory for the MEM stage: byte/half/word loads and stores with a
// valid/ready request handshake, fixed access latency, exception reporting
// and a trace port for committed stores.
module data_mem_ctrl #(
  parameter int unsigned DEPTH     = 3072,
  parameter int unsigned AW        = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;

  localparam logic [1:0] EXC_OK    = 2'b00;
  localparam logic [1:0] EXC_ALIGN = 2'b01;
  localparam logic [1:0] EXC_RANGE = 2'b10;
  localparam logic [1:0] EXC_SIZE  = 2'b11;

  localparam logic [33:0] LIMIT    = 34'(DEPTH) * 34'd4;
  localparam logic [31:0] CNT_INIT = 32'(LATENCY - 1);

  state_t      state, state_next;
  logic [31:0] cnt;
  logic [31:0] mem [DEPTH];

  logic        q_we, q_unsigned;
  logic [1:0]  q_size;
  logic [31:0] q_addr, q_wdata, q_pc;

  logic [31:0] rdata_q;
  logic [1:0]  exc_q;
  logic        trace_q;

  logic        accept, do_access, busy_ok;
  logic [31:0] offset;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic [1:0]  exc;
  logic [31:0] cur_word, load_data, merged, wd, tdata;
  logic [3:0]  be;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  assign req_ready = !reset && (state == IDLE || state == RESP);
  assign accept    = req_valid && req_ready;
  assign do_access = (state == WAIT) && (cnt == '0);
  assign busy_ok   = (exc == EXC_OK);

  // Next-state logic: WAIT counts down, RESP may immediately accept again.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = WAIT;
      WAIT: if (cnt == '0) state_next = RESP;
      RESP: state_next = accept ? WAIT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address decode, exception priority, load extraction and store merge.
  always_comb begin
    offset = q_addr - BASE_ADDR;
    idx    = offset[AW+1:2];
    lane   = offset[1:0];
    exc    = EXC_OK;
    if (q_size == 2'b11)
      exc = EXC_SIZE;
    else if ((q_size == SZ_WORD && lane != 2'b00) || (q_size == SZ_HALF && lane[0]))
      exc = EXC_ALIGN;
    else if (q_addr < BASE_ADDR || {2'b00, offset} >= LIMIT)
      exc = EXC_RANGE;

    cur_word = (exc == EXC_OK) ? mem[idx] : '0;

    case (lane)
      2'd0:    bsel = cur_word[7:0];
      2'd1:    bsel = cur_word[15:8];
      2'd2:    bsel = cur_word[23:16];
      default: bsel = cur_word[31:24];
    endcase
    hsel = lane[1] ? cur_word[31:16] : cur_word[15:0];

    case (q_size)
      SZ_BYTE: load_data = {{24{bsel[7] & ~q_unsigned}}, bsel};
      SZ_HALF: load_data = {{16{hsel[15] & ~q_unsigned}}, hsel};
      default: load_data = cur_word;
    endcase

    case (q_size)
      SZ_BYTE: begin be = 4'b0001 << lane; wd = {4{q_wdata[7:0]}};  tdata = {24'b0, q_wdata[7:0]};  end
      SZ_HALF: begin be = lane[1] ? 4'b1100 : 4'b0011; wd = {2{q_wdata[15:0]}}; tdata = {16'b0, q_wdata[15:0]}; end
      default: begin be = 4'b1111; wd = q_wdata; tdata = q_wdata; end
    endcase

    merged = cur_word;
    for (int unsigned b = 0; b < 4; b++)
      if (be[b]) merged[b*8 +: 8] = wd[b*8 +: 8];
  end

  // State, request latch, latency counter, memory and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      q_we       <= 1'b0;
      q_unsigned <= 1'b0;
      q_size     <= '0;
      q_addr     <= '0;
      q_wdata    <= '0;
      q_pc       <= '0;
      rdata_q    <= '0;
      exc_q      <= '0;
      trace_q    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        q_we       <= req_we;
        q_unsigned <= req_unsigned;
        q_size     <= req_size;
        q_addr     <= req_addr;
        q_wdata    <= req_wdata;
        q_pc       <= req_pc;
        cnt        <= CNT_INIT;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 32'd1;
      end
      if (do_access) begin
        rdata_q <= (!q_we && busy_ok) ? load_data : '0;
        exc_q   <= exc;
        trace_q <= q_we && busy_ok;
        if (q_we && busy_ok) mem[idx] <= merged;
      end
    end
  end

  // The latched request stays valid through RESP because a new accept only
  // overwrites it at the edge that ends the RESP cycle.
  assign resp_valid  = !reset && (state == RESP);
  assign resp_rdata  = resp_valid ? rdata_q : '0;
  assign resp_exc    = resp_valid ? exc_q : '0;
  assign trace_valid = resp_valid && trace_q;
  assign trace_pc    = trace_valid ? q_pc : '0;
  assign trace_addr  = trace_valid ? q_addr : '0;
  assign trace_data  = trace_valid ? tdata : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: instance A uses default parameters (LATENCY 1), instance B
// uses LATENCY 3, a small depth and a non-zero base address.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;

  logic        a_ready, a_resp_valid, a_tv;
  logic [31:0] a_rdata, a_tpc, a_taddr, a_tdata;
  logic [1:0]  a_exc;
  logic        b_ready, b_resp_valid, b_tv;
  logic [31:0] b_rdata, b_tpc, b_taddr, b_tdata;
  logic [1:0]  b_exc;

  int checks = 0;
  int errors = 0;

  bit          sel = 1'b0;
  logic        m_ready, m_resp_valid, m_tv;
  logic [31:0] m_rdata, m_tpc, m_taddr, m_tdata;
  logic [1:0]  m_exc;

  int          r_lat;
  logic [31:0] r_rdata, r_tpc, r_taddr, r_tdata;
  logic [1:0]  r_exc;
  logic        r_tv;

  always #5 clk = ~clk;

  data_mem_ctrl dut_a (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_ready(a_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(a_resp_valid), .resp_rdata(a_rdata), .resp_exc(a_exc),
    .trace_valid(a_tv), .trace_pc(a_tpc), .trace_addr(a_taddr), .trace_data(a_tdata)
  );

  data_mem_ctrl #(.DEPTH(16), .AW(4), .BASE_ADDR(32'h0000_1000), .LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(b_resp_valid), .resp_rdata(b_rdata), .resp_exc(b_exc),
    .trace_valid(b_tv), .trace_pc(b_tpc), .trace_addr(b_taddr), .trace_data(b_tdata)
  );

  // Route the selected instance's outputs to one set of observation signals.
  always_comb begin
    m_ready      = sel ? b_ready      : a_ready;
    m_resp_valid = sel ? b_resp_valid : a_resp_valid;
    m_rdata      = sel ? b_rdata      : a_rdata;
    m_exc        = sel ? b_exc        : a_exc;
    m_tv         = sel ? b_tv         : a_tv;
    m_tpc        = sel ? b_tpc        : a_tpc;
    m_taddr      = sel ? b_taddr      : a_taddr;
    m_tdata      = sel ? b_tdata      : a_tdata;
  end

  // Issue one request from IDLE and capture the response (bounded wait).
  task automatic do_req(input bit s, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] pc);
    int n;
    @(negedge clk);
    sel = s; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_pc = pc;
    if (s) b_valid = 1'b1; else a_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    n = 0;
    while (!m_resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    r_lat = n; r_rdata = m_rdata; r_exc = m_exc; r_tv = m_tv;
    r_tpc = m_tpc; r_taddr = m_taddr; r_tdata = m_tdata;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", a_ready); end
    checks++; if (a_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", a_resp_valid); end
    checks++; if (a_tv !== 1'b0 || a_tdata !== 32'h0) begin errors++; $display("FAIL rst_trace got %b/%h exp 0/0", a_tv, a_tdata); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", a_ready); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready_after got %b exp 1", b_ready); end
  endtask

  task automatic test_word;
    do_req(0, 1'b1, 2'b00, 1'b0, 32'h0, 32'h1234_5678, 32'h0000_0100);
    checks++; if (r_lat !== 1) begin errors++; $display("FAIL sw_latency got %0d exp 1", r_lat); end
    checks++; if (r_exc !== 2'b00 || r_rdata !== 32'h0) begin errors++; $display("FAIL sw_resp got %b/%h exp 00/0", r_exc, r_rdata); end
    checks++; if (r_tv !== 1'b1) begin errors++; $display("FAIL sw_trace_valid got %b exp 1", r_tv); end
    checks++; if (r_tpc !== 32'h100 || r_taddr !== 32'h0 || r_tdata !== 32'h1234_5678)
      begin errors++; $display("FAIL sw_trace got %h/%h/%h exp 00000100/00000000/12345678", r_tpc, r_taddr, r_tdata); end
    do_req(0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0000_0104);
    checks++; if (r_lat !== 1) begin errors++; $display("FAIL lw_latency got %0d exp 1", r_lat); end
    checks++; if (r_rdata !== 32'h1234_5678) begin errors++; $display("FAIL lw_rdata got %h exp 12345678", r_rdata); end
    checks++; if (r_tv !== 1'b0) begin errors++; $display("FAIL lw_trace_valid got %b exp 0", r_tv); end
  endtask

  task automatic test_byte;
    do_req(0, 1'b1, 2'b01, 1'b0, 32'h3, 32'h1234_56AB, 32'h0000_0108);
    checks++; if (r_tv !== 1'b1 || r_taddr !== 32'h3 || r_tdata !== 32'h0000_00AB)
      begin errors++; $display("FAIL sb_trace got %b/%h/%h exp 1/00000003/000000ab", r_tv, r_taddr, r_tdata); end
    do_req(0, 1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 32'h0);
    checks++; if (r_rdata !== 32'hFFFF_FFAB) begin errors++; $display("FAIL lb_rdata got %h exp ffffffab", r_rdata); end
    do_req(0, 1'b0, 2'b01, 1'b1, 32'h3, 32'h0, 32'h0);
    checks++; if (r_rdata !== 32'h0000_00AB) begin errors++; $display("FAIL lbu_rdata got %h exp 000000ab", r_rdata); end
    do_req(0, 1'b0, 2'b01, 1'b0, 32'h1, 32'h0, 32'h0);
    checks++; if (r_rdata !== 32'h0000_0056) begin errors++; $display("FAIL lb1_rdata got %h exp 00000056", r_rdata); end
    do_req(0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
    checks++; if (r_rdata !== 32'hAB34_5678) begin errors++; $display("FAIL sb_word got %h exp ab345678", r_rdata); end
  endtask

  task automatic test_half;
    do_req(0, 1'b1, 2'b00, 1'b0, 32'h4, 32'hCAFE_BABE, 32'h0);
    do_req(0, 1'b1, 2'b10, 1'b0, 32'h6, 32'hDEAD_8001, 32'h0000_0200);
    checks++; if (r_tv !== 1'b1 || r_tdata !== 32'h0000_8001 || r_tpc !== 32'h200)
      begin errors++; $display("FAIL sh_trace got %b/%h/%h exp 1/00008001/00000200", r_tv, r_tdata, r_tpc); end
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'h0);
    checks++; if (r_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_rdata got %h exp ffff8001", r_rdata); end
    do_req(0, 1'b0, 2'b10, 1'b1, 32'h6, 32'h0, 32'h0);
    checks++; if (r_rdata !== 32'h0000_8001) begin errors++; $display("FAIL lhu_rdata got %h exp 00008001", r_rdata); end
    do_req(0, 1'b0, 2'b10, 1'b1, 32'h4, 32'h0, 32'h0);
    checks++; if (r_rdata !== 32'h0000_BABE) begin errors++; $display("FAIL lhu_low_rdata got %h exp 0000babe", r_rdata); end
    do_req(0, 1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 32'h0);
    checks++; if (r_rdata !== 32'h8001_BABE) begin errors++; $display("FAIL sh_word got %h exp 8001babe", r_rdata); end
  endtask

  task automatic test_exceptions;
    do_req(0, 1'b0, 2'b00, 1'b0, 32'h2, 32'h0, 32'h0);
    checks++; if (r_exc !== 2'b01 || r_rdata !== 32'h0 || r_lat !== 1)
      begin errors++; $display("FAIL lw_misalign got %b/%h/%0d exp 01/0/1", r_exc, r_rdata, r_lat); end
    do_req(0, 1'b1, 2'b00, 1'b0, 32'h2, 32'hFFFF_FFFF, 32'h0);
    checks++; if (r_exc !== 2'b01 || r_tv !== 1'b0) begin errors++; $display("FAIL sw_misalign got %b/%b exp 01/0", r_exc, r_tv); end
    do_req(0, 1'b1, 2'b10, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h0);
    checks++; if (r_exc !== 2'b01 || r_tv !== 1'b0 || r_tdata !== 32'h0)
      begin errors++; $display("FAIL sh_misalign got %b/%b/%h exp 01/0/0", r_exc, r_tv, r_tdata); end
    do_req(0, 1'b1, 2'b00, 1'b0, 32'h3000, 32'hFFFF_FFFF, 32'h0);
    checks++; if (r_exc !== 2'b10 || r_tv !== 1'b0) begin errors++; $display("FAIL sw_range got %b/%b exp 10/0", r_exc, r_tv); end
    do_req(0, 1'b0, 2'b00, 1'b0, 32'h2FFC, 32'h0, 32'h0);
    checks++; if (r_exc !== 2'b00 || r_rdata !== 32'h0) begin errors++; $display("FAIL lw_last_word got %b/%h exp 00/0", r_exc, r_rdata); end
    do_req(0, 1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0);
    checks++; if (r_exc !== 2'b11 || r_tv !== 1'b0) begin errors++; $display("FAIL st_illegal got %b/%b exp 11/0", r_exc, r_tv); end
    do_req(0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0);
    checks++; if (r_exc !== 2'b11 || r_rdata !== 32'h0) begin errors++; $display("FAIL ld_illegal got %b/%h exp 11/0", r_exc, r_rdata); end
    do_req(0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
    checks++; if (r_exc !== 2'b00 || r_rdata !== 32'hAB34_5678) begin errors++; $display("FAIL exc_mem0 got %b/%h exp 00/ab345678", r_exc, r_rdata); end
    do_req(0, 1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 32'h0);
    checks++; if (r_rdata !== 32'h8001_BABE) begin errors++; $display("FAIL exc_mem4 got %h exp 8001babe", r_rdata); end
  endtask

  task automatic test_base_range;
    do_req(1, 1'b0, 2'b00, 1'b0, 32'h0000_0FFC, 32'h0, 32'h0);
    checks++; if (r_exc !== 2'b10 || r_lat !== 3) begin errors++; $display("FAIL b_below_base got %b/%0d exp 10/3", r_exc, r_lat); end
    do_req(1, 1'b0, 2'b00, 1'b0, 32'h0000_1040, 32'h0, 32'h0);
    checks++; if (r_exc !== 2'b10) begin errors++; $display("FAIL b_past_end got %b exp 10", r_exc); end
    do_req(1, 1'b1, 2'b00, 1'b0, 32'h0000_103C, 32'h5A5A_1234, 32'h0000_0300);
    checks++; if (r_exc !== 2'b00 || r_tv !== 1'b1 || r_taddr !== 32'h103C)
      begin errors++; $display("FAIL b_last_store got %b/%b/%h exp 00/1/0000103c", r_exc, r_tv, r_taddr); end
    do_req(1, 1'b0, 2'b10, 1'b0, 32'h0000_103E, 32'h0, 32'h0);
    checks++; if (r_rdata !== 32'h0000_5A5A) begin errors++; $display("FAIL b_last_lh got %h exp 00005a5a", r_rdata); end
  endtask

  task automatic test_back_to_back;
    bit exp_ready [10] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 1};
    bit exp_resp  [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    @(negedge clk);
    sel = 1'b1;
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0000_1008; req_wdata = 32'h1111_2222; req_pc = 32'h0000_0400;
    b_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (b_ready !== exp_ready[k]) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp %b", k, b_ready, exp_ready[k]); end
      checks++; if (b_resp_valid !== exp_resp[k]) begin errors++; $display("FAIL b2b_resp_valid[%0d] got %b exp %b", k, b_resp_valid, exp_resp[k]); end
      if (k == 1) begin
        req_we = 1'b0; req_addr = 32'h0000_1008; req_wdata = 32'h0; req_pc = 32'h0000_0404;
      end
      if (k == 4) begin
        checks++; if (b_tv !== 1'b1 || b_tpc !== 32'h400 || b_tdata !== 32'h1111_2222)
          begin errors++; $display("FAIL b2b_store_trace got %b/%h/%h exp 1/00000400/11112222", b_tv, b_tpc, b_tdata); end
      end
      if (k == 8) begin
        checks++; if (b_rdata !== 32'h1111_2222 || b_tv !== 1'b0)
          begin errors++; $display("FAIL b2b_load got %h/%b exp 11112222/0", b_rdata, b_tv); end
        b_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_in_wait;
    int seen;
    do_req(0, 1'b1, 2'b00, 1'b0, 32'h8, 32'h5555_AAAA, 32'h0);
    checks++; if (r_tv !== 1'b1) begin errors++; $display("FAIL pre_store_trace got %b exp 1", r_tv); end
    @(negedge clk);
    sel = 1'b1;
    req_we = 1'b1; req_size = 2'b00; req_addr = 32'h0000_1010; req_wdata = 32'h7777_7777;
    b_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (b_resp_valid || b_tv || a_resp_valid) seen++;
    end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (b_resp_valid || b_tv || a_resp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_drop_resp got %0d strobes exp 0", seen); end
    do_req(1, 1'b0, 2'b00, 1'b0, 32'h0000_1010, 32'h0, 32'h0);
    checks++; if (r_rdata !== 32'h0 || r_exc !== 2'b00) begin errors++; $display("FAIL b_after_reset got %h/%b exp 0/00", r_rdata, r_exc); end
    do_req(0, 1'b0, 2'b00, 1'b0, 32'h8, 32'h0, 32'h0);
    checks++; if (r_rdata !== 32'h0) begin errors++; $display("FAIL a_mem_cleared got %h exp 0", r_rdata); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_exceptions();
    test_base_range();
    test_back_to_back();
    test_reset_in_wait();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
